usb_bus_initiator: RTL



---
 rtl/usb_bus_initiator_pkg.sv | 27 ++
 rtl/usb_bus_initiator_strobe_timer.sv | 26 ++
 rtl/usb_bus_initiator.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/usb_bus_initiator_pkg.sv
// Shared types and parameter helpers for the SAM3U-style parallel register bus initiator.
package usb_bus_initiator_pkg;

    localparam int unsigned TIMER_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_ADDR_STB,
        ST_ADDR_HOLD,
        ST_WAIT_DATA,
        ST_D_SETUP,
        ST_D_STB,
        ST_D_HOLD,
        ST_TURN
    } bus_state_t;

    // Phase widths are loaded as (cycles - 1), so 1..2**TIMER_W is representable.
    function automatic bit cyc_param_ok(input int unsigned cyc);
        return (cyc >= 1) && (cyc <= (1 << TIMER_W));
    endfunction

    function automatic logic [TIMER_W-1:0] timer_load(input int unsigned cyc);
        return TIMER_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/usb_bus_initiator_strobe_timer.sv
// Loadable down-counter timing the setup, strobe, hold and turnaround phases.
module bus_strobe_timer
    import usb_bus_initiator_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/usb_bus_initiator.sv
// Initiator for the 8-bit parallel register bus: CEn-framed ALEn address strobe plus N data strobes.
// The USB_D tristate (usb_d_oe ? usb_d_o : 'z) lives in the board-level wrapper.
module usb_bus_initiator
    import usb_bus_initiator_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic       clk_usb,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_len_m1,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic [7:0] usb_addr_o,
    output logic [7:0] usb_d_o,
    output logic       usb_d_oe,
    input  logic [7:0] usb_d_i,
    output logic       usb_rdn_o,
    output logic       usb_wrn_o,
    output logic       usb_cen_o,
    output logic       usb_alen_o
);

    if (!(cyc_param_ok(SETUP_CYC) && cyc_param_ok(STROBE_CYC) &&
          cyc_param_ok(HOLD_CYC) && cyc_param_ok(TURN_CYC))) begin : g_bad_param
        $error("usb_bus_initiator: phase widths must be in 1..256");
    end

    bus_state_t         r_state;
    bus_state_t         w_state_nxt;

    logic               r_write;
    logic [7:0]         r_remaining;
    logic [7:0]         r_addr;
    logic [7:0]         r_d_o;
    logic [7:0]         r_rd_data;
    logic               r_d_oe;
    logic               r_cmd_ready;
    logic               r_wr_ready;
    logic               r_rd_valid;
    logic               r_busy;
    logic               r_rdn;
    logic               r_wrn;
    logic               r_cen;
    logic               r_alen;

    logic               w_timer_done;
    logic               w_timer_load;
    logic [TIMER_W-1:0] w_timer_val;
    logic               w_cmd_fire;
    logic               w_wr_fire;
    logic               w_rd_sample;
    logic               w_byte_end;

    assign w_cmd_fire  = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;
    assign w_wr_fire   = (r_state == ST_WAIT_DATA) && r_write && r_wr_ready && wr_valid;
    assign w_rd_sample = (r_state == ST_D_STB) && w_timer_done && !r_write;
    assign w_byte_end  = (r_state == ST_D_HOLD) && w_timer_done;

    bus_strobe_timer u_timer (
        .i_clk      (clk_usb),
        .i_rst_n    (reset_n),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:       if (w_cmd_fire)   w_state_nxt = ST_ADDR_SETUP;
            ST_ADDR_SETUP: if (w_timer_done) w_state_nxt = ST_ADDR_STB;
            ST_ADDR_STB:   if (w_timer_done) w_state_nxt = ST_ADDR_HOLD;
            ST_ADDR_HOLD:  if (w_timer_done) w_state_nxt = ST_WAIT_DATA;
            ST_WAIT_DATA:  if (!r_write || w_wr_fire) w_state_nxt = ST_D_SETUP;
            ST_D_SETUP:    if (w_timer_done) w_state_nxt = ST_D_STB;
            ST_D_STB:      if (w_timer_done) w_state_nxt = ST_D_HOLD;
            ST_D_HOLD: begin
                if (w_timer_done) begin
                    w_state_nxt = (r_remaining == '0) ? ST_TURN : ST_WAIT_DATA;
                end
            end
            ST_TURN:       if (w_timer_done) w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    // The timer is reloaded on every state change with the width of the phase being entered.
    always_comb begin
        w_timer_load = (w_state_nxt != r_state);
        w_timer_val  = '0;
        case (w_state_nxt)
            ST_ADDR_SETUP, ST_D_SETUP: w_timer_val = timer_load(SETUP_CYC);
            ST_ADDR_STB,   ST_D_STB:   w_timer_val = timer_load(STROBE_CYC);
            ST_ADDR_HOLD,  ST_D_HOLD:  w_timer_val = timer_load(HOLD_CYC);
            ST_TURN:                   w_timer_val = timer_load(TURN_CYC);
            default:                   w_timer_val = '0;
        endcase
    end

    // Bus outputs are registered from the next state so each strobe is low exactly while its state is current.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_ready <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_cen       <= 1'b1;
            r_alen      <= 1'b1;
            r_rdn       <= 1'b1;
            r_wrn       <= 1'b1;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_wr_ready  <= (w_state_nxt == ST_WAIT_DATA) && r_write;
            r_rd_valid  <= w_rd_sample;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_cen       <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_TURN);
            r_alen      <= (w_state_nxt != ST_ADDR_STB);
            r_rdn       <= !((w_state_nxt == ST_D_STB) && !r_write);
            r_wrn       <= !((w_state_nxt == ST_D_STB) && r_write);
        end
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_d_o       <= '0;
            r_d_oe      <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_write     <= cmd_write;
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len_m1;
            end else if (w_byte_end && (r_remaining != '0)) begin
                r_remaining <= r_remaining - 8'd1;
            end

            if (w_wr_fire) begin
                r_d_o  <= wr_data;
                r_d_oe <= 1'b1;
            end else if ((w_state_nxt == ST_TURN) || (w_state_nxt == ST_IDLE)) begin
                r_d_oe <= 1'b0;
            end

            if (w_rd_sample) begin
                r_rd_data <= usb_d_i;
            end
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign wr_ready   = r_wr_ready;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign busy       = r_busy;
    assign usb_addr_o = r_addr;
    assign usb_d_o    = r_d_o;
    assign usb_d_oe   = r_d_oe;
    assign usb_rdn_o  = r_rdn;
    assign usb_wrn_o  = r_wrn;
    assign usb_cen_o  = r_cen;
    assign usb_alen_o = r_alen;

endmodule
